// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder.
//   CNT_W        : width of the latency down-counter
//   NUM_LANES    : byte lanes per data word
//   dmem_state_e : responder FSM states
//   access_err() : misaligned or empty byte-enable detection
package dmem_pkg;

  localparam int CNT_W     = 4;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  function automatic logic access_err(input logic [1:0]           addr_lo,
                                      input logic [NUM_LANES-1:0] be);
    return (be == '0) || (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables.
// Writes happen on the rising edge of clk; the read port is combinational.
// Contents are never reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address (read and write)
//   wdata : write data
//   be    : byte-lane write enables
//   rdata : word at addr
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [NUM_LANES-1:0] be,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store request at a time, waits
// WAIT_CYCLES extra cycles, performs the access and holds the response
// until it is accepted.
//
// Optional feature: define DMEM_ERR_CHECK_EN to flag accesses with an
// all-zero byte enable or a non word-aligned address. Flagged stores do not
// write, flagged loads return zero. Without it, addr[1:0] is ignored and
// rsp_err is always 0.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   req_valid  : request present
//   req_ready  : request can be accepted (IDLE only)
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   req_be     : byte-lane enables
//   rsp_valid  : response present
//   rsp_ready  : response accepted
//   rsp_rdata  : load data, 0 for stores
//   rsp_err    : access error flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request
// ST_WAIT | counting down extra latency, access happens when cnt is 0
// ST_RESP | response held until rsp_ready
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [NUM_LANES-1:0]  req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int WORD_AW = DM_ADDRESS - 2;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dmem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic commit;
  logic req_hs;

  logic                  cap_write_q;
  logic [DM_ADDRESS-1:0] cap_addr_q;
  logic [DATA_W-1:0]     cap_wdata_q;
  logic [NUM_LANES-1:0]  cap_be_q;

  logic                  acc_write;
  logic [DM_ADDRESS-1:0] acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic [NUM_LANES-1:0]  acc_be;
  logic                  acc_err;

  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  // req_ready is held low while reset is asserted so nothing is accepted
  // (and, with zero latency, nothing committed) during reset.
  assign req_ready = (state_q == ST_IDLE) && reset;
  assign req_hs    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With zero latency the access commits on the handshake edge itself, so
  // the live request is used; otherwise the captured copy is.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = cap_write_q;
      acc_addr  = cap_addr_q;
      acc_wdata = cap_wdata_q;
      acc_be    = cap_be_q;
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  assign acc_err = access_err(acc_addr[1:0], acc_be);
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^acc_addr[1:0];
  assign acc_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_write_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_be_q    <= '0;
    end else if (req_hs) begin
      cap_write_q <= req_write;
      cap_addr_q  <= req_addr;
      cap_wdata_q <= req_wdata;
      cap_be_q    <= req_be;
    end
  end

  assign mem_we = commit && acc_write && !acc_err;

  dmem_array #(
    .ADDR_W (WORD_AW),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_addr[DM_ADDRESS-1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (commit) begin
      rsp_err_q   <= acc_err;
      rsp_rdata_q <= (acc_write || acc_err) ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: main instance with WAIT_CYCLES=2 checked
// through a response scoreboard, plus a WAIT_CYCLES=0 instance for the
// zero-latency path.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [8:0]  z_req_addr;
  logic [31:0] z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;

  data_mem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

`ifdef DMEM_ERR_CHECK_EN
  localparam logic        MIS_ERR   = 1'b1;
  localparam logic [31:0] W010_POST = 32'hDEADBEEF;
`else
  localparam logic        MIS_ERR   = 1'b0;
  localparam logic [31:0] W010_POST = 32'h0BADF00D;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every accepted response with the oldest
  // expectation.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic do_req(input logic wr, input logic [8:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input string name);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic z_req(input logic wr, input logic [8:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input string name);
    int lat;
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1;
    z_req_write = wr;
    z_req_addr  = a;
    z_req_wdata = wd;
    z_req_be    = 4'hF;
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!z_rsp_valid && lat < 20);
    chk({name, "_latency"}, lat, 32'd1);
    chk({name, "_rdata"}, z_rsp_rdata, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready   = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;

    // reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // store then load with latency
    do_req(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3, "st010");
    do_req(1'b0, 9'h010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3, "ld010");

    // partial store
    do_req(1'b1, 9'h020, 32'h11223344, 4'hF, 32'h0, 1'b0, 3, "st020");
    do_req(1'b1, 9'h020, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, 3, "st020_part");
    do_req(1'b0, 9'h020, 32'h0, 4'hF, 32'h1122AA44, 1'b0, 3, "ld020");

    // backpressure; a store presented during RESP must be ignored
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_req(1'b0, 9'h020, 32'h0, 4'hF, 32'h1122AA44, 1'b0, 3, "ld020_bp");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h020; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h1122AA44);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 begin
      rsp_ready = 1'b1;
      req_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    do_req(1'b0, 9'h020, 32'h0, 4'hF, 32'h1122AA44, 1'b0, 3, "ld020_after_bp");

    // misaligned store
    do_req(1'b1, 9'h013, 32'h0BADF00D, 4'hF, 32'h0, MIS_ERR, 3, "st013");
    do_req(1'b0, 9'h010, 32'h0, 4'hF, W010_POST, 1'b0, 3, "ld010_post");
`ifdef DMEM_ERR_CHECK_EN
    do_req(1'b0, 9'h011, 32'h0, 4'hF, 32'h0, 1'b1, 3, "ld011_err");
    do_req(1'b1, 9'h010, 32'h12345678, 4'h0, 32'h0, 1'b1, 3, "st010_be0");
    do_req(1'b0, 9'h010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3, "ld010_be0");
`endif

    // reset while a store waits
    do_req(1'b1, 9'h030, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 3, "st030");
    @(negedge clk);
    chk("rw_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h030; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rw_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 chk("rw_req_ready_rel", {31'd0, req_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_req(1'b0, 9'h030, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 3, "ld030");

    // zero latency instance
    z_req(1'b1, 9'h044, 32'h55AA55AA, 32'h0, "z_st044");
    z_req(1'b0, 9'h044, 32'h0, 32'h55AA55AA, "z_ld044");

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, meaning byte-address width; storage depth is 2^(DM_ADDRESS-2) words.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data word width; only 32 is supported.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning extra access latency in cycles.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port req_valid, input, 1 bit: request present.
REQ-007 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, DM_ADDRESS bits: byte address.
REQ-010 SHALL have port req_wdata, input, DATA_W bits: store data.
REQ-011 SHALL have port req_be, input, 4 bits: byte-lane enables, bit i selecting wdata[8i+7:8i].
REQ-012 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-013 SHALL have port rsp_ready, input, 1 bit: requester accepts the response.
REQ-014 SHALL have port rsp_rdata, output, DATA_W bits: load data, or 0 for stores.
REQ-015 SHALL have port rsp_err, output, 1 bit: access error flag.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL, on a request handshake (req_valid && req_ready), capture write, addr, wdata and be.
- Next state is WAIT with a down-counter loaded with WAIT_CYCLES-1.
- If WAIT_CYCLES=0, next state is RESP directly.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the cycle the counter reads 0.
REQ-020 SHALL perform the memory access on the edge that enters RESP.
- Store: writes only the lanes enabled in be.
- Load: registers the full word at addr[DM_ADDRESS-1:2] into rsp_rdata.
REQ-021 SHALL hold rsp_valid=1 throughout RESP, with rsp_rdata and rsp_err stable until the response handshake (rsp_valid && rsp_ready).
REQ-022 SHALL return to IDLE on the response handshake.
- rsp_valid deasserts the next cycle.
- The response handshake cycle does not accept a new request.
REQ-023 SHALL give a first-rsp_valid latency of WAIT_CYCLES+1 cycles after the request handshake edge.
- Peak throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-024 SHALL drive rsp_rdata=0 for store responses.
REQ-025 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-026 SHALL, on reset=0, immediately force the following regardless of clk:
- state=IDLE, counter=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0;
- req_ready=1 once reset=1.
REQ-027 SHALL drop an in-flight transaction on reset; an uncommitted store SHALL NOT modify memory.
REQ-028 SHALL NOT reset memory contents; they are undefined until written.

Configuration
REQ-029 SHALL support the macro DMEM_ERR_CHECK_EN.
- Defined: rsp_err=1 when req_be==4'b0000 or req_addr[1:0]!=0. An errored store leaves memory unchanged; an errored load returns rsp_rdata=0. Latency is unchanged.
- Undefined: req_addr[1:0] is ignored, rsp_err is tied 0, and every access executes.

Structure
REQ-030 SHALL take the FSM state enum, the WAIT_CYCLES counter width constant (4) and the byte-lane count (4) from shared package dmem_pkg.
REQ-031 SHALL instantiate one sub-module, dmem_array: a synchronous word array with per-byte write enables and a combinational read port.

Verification (bench uses WAIT_CYCLES=2 unless stated)
REQ-032 SHALL check store then load with latency:
- Store addr=0x010, wdata=0xDEADBEEF, be=4'hF, then load addr=0x010.
- Required: rdata=0xDEADBEEF; rsp_valid rises 3 cycles after each request handshake.
REQ-033 SHALL check partial store:
- Store 0x11223344 to 0x020, then store be=4'b0010 wdata=0x0000AA00 to 0x020, then load 0x020.
- Required: rdata=0x1122AA44.
REQ-034 SHALL check backpressure:
- Hold rsp_ready=0 for 5 cycles during a load response.
- Required: rsp_valid stays 1, rdata stays constant, req_ready stays 0; return to IDLE one cycle after rsp_ready=1.
REQ-035 SHALL check error handling with DMEM_ERR_CHECK_EN:
- Store to addr=0x013 with be=4'hF.
- Required: rsp_err=1 and the word at 0x010 is unchanged.
- Without the macro: the same store writes the word at 0x010 and rsp_err=0.
REQ-036 SHALL check reset mid-operation:
- Assert reset=0 while in WAIT on a store to 0x030.
- Required: rsp_valid=0 immediately; after release, req_ready=1; a later load of 0x030 returns the prior contents.
REQ-037 SHALL check zero latency:
- With WAIT_CYCLES=0, issue a load.
- Required: rsp_valid asserts 1 cycle after the request handshake.
